// File: rtl/uart_rx_pkg.sv
// Shared constants for the Wishbone UART receiver: register offsets,
// STATUS bit positions and the receiver state encoding.
package uart_rx_pkg;

    // Word offsets, decoded from adr[3:2]
    localparam logic [1:0] REG_RXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERRUN   = 2;
    localparam int ST_FRAME_ERR = 3;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

endpackage

// File: rtl/uart_rx_wb_if.sv
// Wishbone B4 classic bus bundle for the UART receiver slave port.
interface uart_rx_wb_if;

    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat_m2s;
    logic [31:0] dat_s2m;
    logic        ack;

    modport master (output cyc, stb, we, adr, dat_m2s, input dat_s2m, ack);
    modport slave  (input cyc, stb, we, adr, dat_m2s, output dat_s2m, ack);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; a pop while full lets a simultaneous push in.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_wb.sv
// 8N1 UART receiver with a receive FIFO, polled through three Wishbone
// registers: RXDATA (pop), STATUS and CTRL (sticky error clears).
module uart_rx_wb
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic         clk,
    input  logic         rst,
    uart_rx_wb_if.slave  wb,
    input  logic         rx
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);

    logic          rx_meta;
    logic          rx_sync;
    rx_state_t     state;
    rx_state_t     state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_nxt;
    logic [7:0]    shift;
    logic [7:0]    shift_nxt;
    logic          armed;
    logic          armed_nxt;
    logic          frame_ok;
    logic          frame_bad;

    logic          fifo_push;
    logic          fifo_pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [AW:0]   fifo_count;

    logic          req;
    logic          rd_req;
    logic          ctrl_wr;
    logic [1:0]    reg_sel;
    logic [31:0]   status;
    logic [31:0]   rdata;
    logic          overrun;
    logic          frame_err;
    logic          set_overrun;
    logic          unused_bits;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            armed   <= 1'b1;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shift   <= shift_nxt;
            armed   <= armed_nxt;
        end
    end

    // armed drops after every stop bit so a held-low line is not taken as a new start
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt - 1'b1;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        armed_nxt   = armed | rx_sync;
        frame_ok    = 1'b0;
        frame_bad   = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = cnt;
                if (armed && !rx_sync) begin
                    state_nxt = START;
                    cnt_nxt   = HALF_LOAD;
                end
            end
            START: begin
                if (cnt == '0) begin
                    cnt_nxt     = BIT_LOAD;
                    bit_idx_nxt = '0;
                    state_nxt   = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    shift_nxt = {rx_sync, shift[7:1]};
                    cnt_nxt   = BIT_LOAD;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (cnt == '0) begin
                    frame_ok  = rx_sync;
                    frame_bad = ~rx_sync;
                    armed_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign reg_sel     = wb.adr[3:2];
    assign req         = wb.cyc & wb.stb & ~wb.ack;
    assign rd_req      = req & ~wb.we;
    assign ctrl_wr     = req & wb.we & (reg_sel == REG_CTRL);
    assign fifo_pop    = rd_req & (reg_sel == REG_RXDATA) & ~fifo_empty;
    assign fifo_push   = frame_ok & (~fifo_full | fifo_pop);
    assign set_overrun = frame_ok & fifo_full & ~fifo_pop;
    assign unused_bits = ^{wb.adr[31:4], wb.adr[1:0], wb.dat_m2s[31:2]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (shift),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        status               = '0;
        status[15:8]         = 8'(fifo_count);
        status[ST_FRAME_ERR] = frame_err;
        status[ST_OVERRUN]   = overrun;
        status[ST_FULL]      = fifo_full;
        status[ST_NOT_EMPTY] = ~fifo_empty;
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_RXDATA: rdata = fifo_empty ? 32'h0 : {24'h0, fifo_dout};
            REG_STATUS: rdata = status;
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb.ack     <= 1'b0;
            wb.dat_s2m <= '0;
        end else begin
            wb.ack     <= req;
            wb.dat_s2m <= rd_req ? rdata : 32'h0;
        end
    end

    // Error events take priority over a same-cycle software clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (set_overrun) begin
                overrun <= 1'b1;
            end else if (ctrl_wr && wb.dat_m2s[0]) begin
                overrun <= 1'b0;
            end
            if (frame_bad) begin
                frame_err <= 1'b1;
            end else if (ctrl_wr && wb.dat_m2s[1]) begin
                frame_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_wb.sv
// Self-checking bench for uart_rx_wb: directed frames plus a randomized run,
// all checked against a queue-based model of the receiver's registers.
module tb_uart_rx_wb;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;

    int checks   = 0;
    int failures = 0;

    logic [7:0] model_q[$];
    logic       model_over = 1'b0;
    logic       model_ferr = 1'b0;

    uart_rx_wb_if wb();

    uart_rx_wb #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb.slave),
        .rx  (rx)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_status();
        return {16'h0, 8'(model_q.size()), 4'h0, model_ferr, model_over,
                model_q.size() == DEPTH, model_q.size() != 0};
    endfunction

    task automatic model_frame(input logic [7:0] b, input logic stop);
        if (!stop) model_ferr = 1'b1;
        else if (model_q.size() < DEPTH) model_q.push_back(b);
        else model_over = 1'b1;
    endtask

    task automatic model_reset();
        model_q.delete();
        model_over = 1'b0;
        model_ferr = 1'b0;
    endtask

    // Starts at the next falling edge; returns after the stop bit plus a short idle gap
    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic wb_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rdata);
        int waited;
        @(negedge clk);
        wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = we; wb.adr = addr; wb.dat_m2s = wdata;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!wb.ack && waited < 8);
        check_output("ack_seen", {31'h0, wb.ack}, 32'h1);
        rdata = wb.dat_s2m;
        wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
    endtask

    task automatic read_check(input logic [31:0] addr, input string tag);
        logic [31:0] exp;
        logic [31:0] got;
        case (addr[3:2])
            2'd0:    exp = (model_q.size() != 0) ? {24'h0, model_q.pop_front()} : 32'h0;
            2'd1:    exp = exp_status();
            default: exp = 32'h0;
        endcase
        wb_access(1'b0, addr, 32'h0, got);
        check_output(tag, got, exp);
    endtask

    task automatic write_reg(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] dummy;
        wb_access(1'b1, addr, data, dummy);
        if (addr[3:2] == 2'd2) begin
            if (data[0]) model_over = 1'b0;
            if (data[1]) model_ferr = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0]  b;
        logic        stop;
        logic [31:0] junk;
        logic [31:0] addr;
        int          nrd;

        wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0; wb.adr = '0; wb.dat_m2s = '0;
        repeat (3) @(negedge clk);
        check_output("reset_ack", {31'h0, wb.ack}, 32'h0);
        check_output("reset_dat", wb.dat_s2m, 32'h0);
        rst = 1'b0;
        read_check(32'h4, "reset_status");

        send_frame(8'hA5, 1'b1);
        model_frame(8'hA5, 1'b1);
        read_check(32'h4, "a5_status");
        read_check(32'h0, "a5_rxdata");
        read_check(32'h4, "a5_status_after");

        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        read_check(32'h4, "glitch_status");

        for (int i = 1; i <= 5; i++) begin
            b = 8'(i * 17);
            send_frame(b, 1'b1);
            model_frame(b, 1'b1);
        end
        read_check(32'h4, "overrun_status");
        for (int i = 0; i < 4; i++) read_check(32'h0, "overrun_data");
        write_reg(32'h8, 32'h1);
        read_check(32'h4, "overrun_cleared");

        send_frame(8'h3C, 1'b0);
        model_frame(8'h3C, 1'b0);
        read_check(32'h4, "frame_err_status");
        write_reg(32'h8, 32'h2);
        read_check(32'h4, "frame_err_cleared");

        // Fill the FIFO, then land a RXDATA pop ack on the 5th stop-bit sample edge
        for (int i = 0; i < 4; i++) begin
            b = 8'hA1 + 8'(i);
            send_frame(b, 1'b1);
            model_frame(b, 1'b1);
        end
        fork
            send_frame(8'h5A, 1'b1);
            begin
                repeat (78) @(negedge clk);
                read_check(32'h0, "pop_at_push_data");
            end
        join
        model_frame(8'h5A, 1'b1);
        read_check(32'h4, "pop_at_push_status");
        for (int i = 0; i < 4; i++) read_check(32'h0, "pop_at_push_drain");
        read_check(32'h4, "pop_at_push_empty");

        // Reset during data bit 3 of 0xF8 (bits 3..7 high, so nothing restarts afterwards)
        fork
            send_frame(8'hF8, 1'b1);
            begin
                repeat (34) @(negedge clk);
                wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b0; wb.adr = 32'h4;
                @(negedge clk);
                rst = 1'b1;
                #1;
                check_output("rst_drops_ack", {31'h0, wb.ack}, 32'h0);
                @(negedge clk);
                check_output("rst_hold_ack", {31'h0, wb.ack}, 32'h0);
                check_output("rst_hold_dat", wb.dat_s2m, 32'h0);
                @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                check_output("rst_release_ack", {31'h0, wb.ack}, 32'h1);
                check_output("rst_release_status", wb.dat_s2m, 32'h0);
                wb.cyc = 1'b0; wb.stb = 1'b0;
            end
        join
        model_reset();
        read_check(32'h4, "post_reset_status");
        send_frame(8'h7E, 1'b1);
        model_frame(8'h7E, 1'b1);
        read_check(32'h4, "post_reset_7e_status");
        read_check(32'h0, "post_reset_7e_data");

        read_check(32'h8, "ctrl_reads_zero");
        read_check(32'hC, "reserved_reads_zero");

        for (int n = 0; n < 24; n++) begin
            b    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 4) != 0);
            send_frame(b, stop);
            model_frame(b, stop);
            nrd = $urandom_range(0, 2);
            for (int k = 0; k < nrd; k++) read_check(32'h0, "rand_rxdata");
            if ($urandom_range(0, 2) == 0) begin
                junk = $urandom();
                addr = {junk[31:4], 2'($urandom_range(0, 3)), 2'b00};
                write_reg(addr, $urandom());
            end
            junk = $urandom();
            read_check({junk[31:4], 4'h4}, "rand_status");
        end
        while (model_q.size() != 0) read_check(32'h0, "drain_rxdata");
        read_check(32'h4, "drain_status");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
